axil_reg_slave: RTL and testbench

AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

---
 rtl/axil_reg_slave.sv | 173 +++++++++++++++++
 tb/tb_axil_reg_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register file: independent AW/W holding registers, one write outstanding, 1-cycle reads.
// Define AXIL_REG_SLAVE_DECERR_EN to answer out-of-range accesses with DECERR instead of OKAY.
module axil_reg_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int STRB_WIDTH = DATA_WIDTH/8,
   parameter int REG_COUNT  = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [ADDR_WIDTH-1:0]            s_axil_awaddr,
   input  logic [2:0]                       s_axil_awprot,
   input  logic                             s_axil_awvalid,
   output logic                             s_axil_awready,
   input  logic [DATA_WIDTH-1:0]            s_axil_wdata,
   input  logic [STRB_WIDTH-1:0]            s_axil_wstrb,
   input  logic                             s_axil_wvalid,
   output logic                             s_axil_wready,
   output logic [1:0]                       s_axil_bresp,
   output logic                             s_axil_bvalid,
   input  logic                             s_axil_bready,
   input  logic [ADDR_WIDTH-1:0]            s_axil_araddr,
   input  logic [2:0]                       s_axil_arprot,
   input  logic                             s_axil_arvalid,
   output logic                             s_axil_arready,
   output logic [DATA_WIDTH-1:0]            s_axil_rdata,
   output logic [1:0]                       s_axil_rresp,
   output logic                             s_axil_rvalid,
   input  logic                             s_axil_rready,
   output logic [REG_COUNT*DATA_WIDTH-1:0]  reg_out
);
   localparam int LSB   = $clog2(STRB_WIDTH);
   localparam int IDX_W = ADDR_WIDTH - LSB;
   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_SLAVE_DECERR_EN
   localparam logic [1:0] RESP_OOR = 2'b11;
`else
   localparam logic [1:0] RESP_OOR = 2'b00;
`endif

   logic                  aw_full_q, aw_full_d, awready_q, awready_d;
   logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
   logic                  w_full_q, w_full_d, wready_q, wready_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  arready_q, arready_d, rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

   logic                  aw_hs, w_hs, ar_hs, commit, aw_in_range, ar_in_range;
   logic [IDX_W-1:0]      ar_idx;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  unused_ok;

   // Protection bits and sub-word address bits carry no meaning for this register file.
   assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[LSB-1:0], s_axil_araddr[LSB-1:0]};

   assign aw_hs       = s_axil_awvalid && awready_q;
   assign w_hs        = s_axil_wvalid && wready_q;
   assign ar_hs       = s_axil_arvalid && arready_q;
   assign commit      = aw_full_q && w_full_q && (!bvalid_q || s_axil_bready);
   assign ar_idx      = s_axil_araddr[ADDR_WIDTH-1:LSB];
   assign aw_in_range = 32'(aw_idx_q) < REG_COUNT;
   assign ar_in_range = 32'(ar_idx) < REG_COUNT;

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < REG_COUNT; i++)
         if (32'(ar_idx) == i) rd_word = regs_q[i];
   end

   always_comb begin
      aw_full_d = aw_full_q;
      aw_idx_d  = aw_idx_q;
      w_full_d  = w_full_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      if (aw_hs) begin
         aw_full_d = 1'b1;
         aw_idx_d  = s_axil_awaddr[ADDR_WIDTH-1:LSB];
      end
      if (w_hs) begin
         w_full_d = 1'b1;
         w_data_d = s_axil_wdata;
         w_strb_d = s_axil_wstrb;
      end
      // A B handshake and a new commit on the same edge keep bvalid high with the new response.
      if (commit) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = aw_in_range ? RESP_OKAY : RESP_OOR;
      end else if (s_axil_bready) begin
         bvalid_d  = 1'b0;
      end
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = ar_in_range ? rd_word : '0;
         rresp_d  = ar_in_range ? RESP_OKAY : RESP_OOR;
      end else if (s_axil_rready) begin
         rvalid_d = 1'b0;
      end
      awready_d = !aw_full_d;
      wready_d  = !w_full_d;
      arready_d = !rvalid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_full_q <= 1'b0;
         aw_idx_q  <= '0;
         awready_q <= 1'b0;
         w_full_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
      end else begin
         aw_full_q <= aw_full_d;
         aw_idx_q  <= aw_idx_d;
         awready_q <= awready_d;
         w_full_q  <= w_full_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // Register file: out-of-range commits match no index and are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < REG_COUNT; i++)
            if (commit && 32'(aw_idx_q) == i)
               for (int k = 0; k < STRB_WIDTH; k++)
                  if (w_strb_q[k]) regs_q[i][k*8 +: 8] <= w_data_q[k*8 +: 8];
      end
   end

   for (genvar g = 0; g < REG_COUNT; g++) begin : g_out
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
   end

   assign s_axil_awready = awready_q;
   assign s_axil_wready  = wready_q;
   assign s_axil_bvalid  = bvalid_q;
   assign s_axil_bresp   = bresp_q;
   assign s_axil_arready = arready_q;
   assign s_axil_rvalid  = rvalid_q;
   assign s_axil_rdata   = rdata_q;
   assign s_axil_rresp   = rresp_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave (default 32-bit data, 8-bit address, 16 registers).
module tb_axil_reg_slave;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [7:0]   awaddr = '0, araddr = '0;
   logic [2:0]   awprot = '0, arprot = '0;
   logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [31:0]  wdata = '0;
   logic [3:0]   wstrb = '0;
   logic         awready, wready, bvalid, arready, rvalid;
   logic [1:0]   bresp, rresp;
   logic [31:0]  rdata;
   logic [511:0] reg_out;

   logic [31:0]  exp_reg [16];
   int           total = 0;
   int           bad = 0;

`ifdef AXIL_REG_SLAVE_DECERR_EN
   localparam logic [1:0] OOR = 2'b11;
`else
   localparam logic [1:0] OOR = 2'b00;
`endif

   axil_reg_slave dut (
      .clk(clk), .rst(rst),
      .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
      .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
      .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
      .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
      .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
      .reg_out(reg_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] exp_vec();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = exp_reg[i];
      return v;
   endfunction

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      tick();
      bready = 1'b1;
      tick();
      bready = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
      araddr = a; arvalid = 1'b1;
      tick();
      d = rdata; r = rresp;
      arvalid = 1'b0; rready = 1'b1;
      tick();
      rready = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 16; i++) exp_reg[i] = '0;
      repeat (3) tick();
      total++; if ({awready, wready, arready} !== 3'b000) begin bad++; $display("FAIL rst_readies got=%b exp=000", {awready, wready, arready}); end
      total++; if ({bvalid, rvalid} !== 2'b00) begin bad++; $display("FAIL rst_valids got=%b exp=00", {bvalid, rvalid}); end
      total++; if ({bresp, rresp, rdata} !== 36'h0) begin bad++; $display("FAIL rst_resp_data got=%h exp=0", {bresp, rresp, rdata}); end
      total++; if (reg_out !== exp_vec()) begin bad++; $display("FAIL rst_regs got=%h exp=%h", reg_out, exp_vec()); end
      rst = 1'b0;
      total++; if (awready !== 1'b0) begin bad++; $display("FAIL rst_release_low got=%b exp=0", awready); end
      tick();
      total++; if ({awready, wready, arready} !== 3'b111) begin bad++; $display("FAIL rst_release_high got=%b exp=111", {awready, wready, arready}); end
   endtask

   task automatic test_basic();
      awaddr = 8'h04; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      total++; if ({awready, wready, bvalid} !== 3'b000) begin bad++; $display("FAIL basic_held got=%b exp=000", {awready, wready, bvalid}); end
      tick();
      exp_reg[1] = 32'hDEADBEEF;
      total++; if ({bvalid, bresp} !== 3'b100) begin bad++; $display("FAIL basic_b got=%b exp=100", {bvalid, bresp}); end
      total++; if (reg_out !== exp_vec()) begin bad++; $display("FAIL basic_regs got=%h exp=%h", reg_out, exp_vec()); end
      total++; if ({awready, wready} !== 2'b11) begin bad++; $display("FAIL basic_ready_back got=%b exp=11", {awready, wready}); end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL basic_b_drain got=%b exp=0", bvalid); end
      araddr = 8'h04; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      total++; if ({rvalid, arready, rresp} !== 4'b1000) begin bad++; $display("FAIL basic_r_ctl got=%b exp=1000", {rvalid, arready, rresp}); end
      total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rdata got=%h exp=deadbeef", rdata); end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      total++; if ({rvalid, arready} !== 2'b01) begin bad++; $display("FAIL basic_r_drain got=%b exp=01", {rvalid, arready}); end
   endtask

   task automatic test_w_before_aw();
      logic [31:0] d;
      logic [1:0]  r;
      wr(8'h08, 32'h11223344, 4'hF);
      wdata = 32'h000000AA; wstrb = 4'h1; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      total++; if ({wready, awready} !== 2'b01) begin bad++; $display("FAIL wfirst_ready got=%b exp=01", {wready, awready}); end
      for (int c = 0; c < 2; c++) begin
         tick();
         total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL wfirst_wait%0d got=%b exp=0", c, bvalid); end
      end
      awaddr = 8'h08; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL wfirst_aw_edge got=%b exp=0", bvalid); end
      tick();
      exp_reg[2] = 32'h112233AA;
      total++; if ({bvalid, bresp} !== 3'b100) begin bad++; $display("FAIL wfirst_b got=%b exp=100", {bvalid, bresp}); end
      total++; if (reg_out !== exp_vec()) begin bad++; $display("FAIL wfirst_regs got=%h exp=%h", reg_out, exp_vec()); end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      rd(8'h0A, d, r);
      total++; if ({d, r} !== {32'h112233AA, 2'b00}) begin bad++; $display("FAIL wfirst_read got=%h exp=%h", {d, r}, {32'h112233AA, 2'b00}); end
   endtask

   task automatic test_b_backpressure();
      awaddr = 8'h0C; awvalid = 1'b1; wdata = 32'h00000055; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      tick();
      exp_reg[3] = 32'h00000055;
      total++; if ({bvalid, awready} !== 2'b11) begin bad++; $display("FAIL bp_first got=%b exp=11", {bvalid, awready}); end
      awaddr = 8'h10; awvalid = 1'b1; wdata = 32'h00000066; wvalid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         awvalid = 1'b0; wvalid = 1'b0;
         total++; if ({bvalid, bresp, awready, wready} !== 5'b10000) begin bad++; $display("FAIL bp_hold%0d got=%b exp=10000", c, {bvalid, bresp, awready, wready}); end
      end
      total++; if (reg_out !== exp_vec()) begin bad++; $display("FAIL bp_regs_hold got=%h exp=%h", reg_out, exp_vec()); end
      bready = 1'b1;
      tick();
      exp_reg[4] = 32'h00000066;
      total++; if ({bvalid, bresp, awready} !== 4'b1001) begin bad++; $display("FAIL bp_overlap got=%b exp=1001", {bvalid, bresp, awready}); end
      total++; if (reg_out !== exp_vec()) begin bad++; $display("FAIL bp_regs got=%h exp=%h", reg_out, exp_vec()); end
      tick();
      bready = 1'b0;
      total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", bvalid); end
   endtask

   task automatic test_out_of_range();
      araddr = 8'h40; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      total++; if ({rvalid, rresp} !== {1'b1, OOR}) begin bad++; $display("FAIL oor_rresp got=%b exp=%b", {rvalid, rresp}, {1'b1, OOR}); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL oor_rdata got=%h exp=0", rdata); end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      awaddr = 8'h40; awvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      tick();
      total++; if ({bvalid, bresp} !== {1'b1, OOR}) begin bad++; $display("FAIL oor_bresp got=%b exp=%b", {bvalid, bresp}, {1'b1, OOR}); end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      total++; if (reg_out !== exp_vec()) begin bad++; $display("FAIL oor_regs got=%h exp=%h", reg_out, exp_vec()); end
   endtask

   task automatic test_same_edge();
      logic [31:0] d;
      logic [1:0]  r;
      wr(8'h00, 32'h00000001, 4'hF);
      awaddr = 8'h00; awvalid = 1'b1; wdata = 32'h00000002; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 8'h00; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      total++; if ({rvalid, bvalid} !== 2'b11) begin bad++; $display("FAIL same_valids got=%b exp=11", {rvalid, bvalid}); end
      total++; if (rdata !== 32'h00000001) begin bad++; $display("FAIL same_old got=%h exp=00000001", rdata); end
      rready = 1'b1; bready = 1'b1;
      tick();
      rready = 1'b0; bready = 1'b0;
      exp_reg[0] = 32'h00000002;
      rd(8'h00, d, r);
      total++; if (d !== 32'h00000002) begin bad++; $display("FAIL same_new got=%h exp=00000002", d); end
   endtask

   task automatic test_reset_mid();
      awaddr = 8'h14; awvalid = 1'b1; araddr = 8'h04; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; arvalid = 1'b0;
      total++; if ({awready, rvalid} !== 2'b01) begin bad++; $display("FAIL mid_pending got=%b exp=01", {awready, rvalid}); end
      rst = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) exp_reg[i] = '0;
      total++; if ({bvalid, rvalid, awready, wready, arready} !== 5'b0) begin bad++; $display("FAIL mid_rst got=%b exp=00000", {bvalid, rvalid, awready, wready, arready}); end
      total++; if (reg_out !== exp_vec()) begin bad++; $display("FAIL mid_regs got=%h exp=%h", reg_out, exp_vec()); end
      rst = 1'b0;
      total++; if ({awready, wready, arready} !== 3'b000) begin bad++; $display("FAIL mid_release_low got=%b exp=000", {awready, wready, arready}); end
      tick();
      total++; if ({awready, wready, arready, rvalid} !== 4'b1110) begin bad++; $display("FAIL mid_release_high got=%b exp=1110", {awready, wready, arready, rvalid}); end
      wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      tick();
      total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL mid_aw_discarded got=%b exp=0", bvalid); end
      awaddr = 8'h14; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      tick();
      exp_reg[5] = 32'hCAFEF00D;
      total++; if ({bvalid, bresp} !== 3'b100) begin bad++; $display("FAIL mid_after_b got=%b exp=100", {bvalid, bresp}); end
      total++; if (reg_out !== exp_vec()) begin bad++; $display("FAIL mid_after_regs got=%h exp=%h", reg_out, exp_vec()); end
      bready = 1'b1;
      tick();
      bready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_w_before_aw();
      test_b_backpressure();
      test_out_of_range();
      test_same_edge();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
